// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide sequencer:
// funct3 op codes, FSM state encoding and the default datapath width.
package muldiv_sequencer_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer handshake. The pipeline (master)
// offers an M-op and control; the sequencer (slave) answers with stall/result.
interface muldiv_sequencer_if #(
  parameter int XLEN = muldiv_sequencer_pkg::XLEN_DEF
);
  logic            start_E;
  logic [2:0]      op_E;
  logic [XLEN-1:0] a_E;
  logic [XLEN-1:0] b_E;
  logic            flush_E;
  logic            hold_E;
  logic            stall_md;
  logic            done_md;
  logic [XLEN-1:0] result_md;

  modport master (
    output start_E, op_E, a_E, b_E, flush_E, hold_E,
    input  stall_md, done_md, result_md
  );

  modport slave (
    input  start_E, op_E, a_E, b_E, flush_E, hold_E,
    output stall_md, done_md, result_md
  );
endinterface

// File: rtl/muldiv_sequencer_step.sv
// One iteration of the datapath: shift-add multiply step on {hi,lo} or one
// restoring-divide step (remainder in hi, dividend/quotient shifting through lo).
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    shifted = {hi, lo[XLEN-1]};
    // A set carry-out bit means the shifted remainder already exceeds any divisor.
    fits    = shifted[XLEN] | (shifted[XLEN-1:0] >= m);
    diff    = shifted[XLEN-1:0] - m;
    if (is_div) begin
      hi_n = fits ? diff : shifted[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], fits};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M sequencer: latches one op from EX, iterates XLEN cycles
// (or short-cuts divide specials), stalls the pipe and presents the result in FIN.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  state_t          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] hi_q, lo_q, m_q, result_q;
  logic [CW-1:0]   count_q;
  logic            neg_q, neg_rem_q, done_q;

  logic            is_div, a_signed, b_signed, sa, sb, div0, ovf, special, neg_ld;
  logic [XLEN-1:0] a_mag, b_mag, hi_ld, lo_ld, m_ld, hi_s, lo_s, fin_ld, fin_step;

  function automatic logic [XLEN-1:0] finalize(input logic [2:0] op,
      input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo,
      input logic neg, input logic neg_rem);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    prod = neg ? -{hi, lo} : {hi, lo};
    quo  = neg ? -lo : lo;
    rem  = neg_rem ? -hi : hi;
    if (op[2])      return op[1] ? rem : quo;
    else if (op == OP_MUL) return prod[XLEN-1:0];
    else            return prod[2*XLEN-1:XLEN];
  endfunction

  always_comb begin
    is_div   = bus.op_E[2];
    a_signed = (bus.op_E == OP_MULH) || (bus.op_E == OP_MULHSU) ||
               (bus.op_E == OP_DIV)  || (bus.op_E == OP_REM);
    b_signed = (bus.op_E == OP_MULH) || (bus.op_E == OP_DIV) || (bus.op_E == OP_REM);
    sa       = a_signed & bus.a_E[XLEN-1];
    sb       = b_signed & bus.b_E[XLEN-1];
    a_mag    = sa ? -bus.a_E : bus.a_E;
    b_mag    = sb ? -bus.b_E : bus.b_E;
    div0     = is_div && (bus.b_E == '0);
    ovf      = is_div && b_signed && (bus.a_E == {1'b1, {(XLEN-1){1'b0}}}) &&
               (bus.b_E == '1);
    special  = FAST_SPECIAL && (div0 || ovf);
    // Divide-by-zero quotient is all ones regardless of the dividend's sign.
    neg_ld   = (sa ^ sb) & ~div0;
    // The fast divide-by-zero path preloads the already-final quotient/remainder.
    hi_ld    = (special && div0) ? a_mag : '0;
    lo_ld    = (special && div0) ? '1 : (is_div ? a_mag : b_mag);
    m_ld     = is_div ? b_mag : a_mag;
    fin_ld   = finalize(bus.op_E, hi_ld, lo_ld, neg_ld, sa);
    fin_step = finalize(op_q, hi_s, lo_s, neg_q, neg_rem_q);
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (op_q[2]),
    .hi     (hi_q),
    .lo     (lo_q),
    .m      (m_q),
    .hi_n   (hi_s),
    .lo_n   (lo_s)
  );

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values; blocking here would chain updates in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_MUL;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else if (bus.flush_E) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start_E) begin
          op_q      <= bus.op_E;
          hi_q      <= hi_ld;
          lo_q      <= lo_ld;
          m_q       <= m_ld;
          neg_q     <= neg_ld;
          neg_rem_q <= sa;
          count_q   <= CW'(XLEN - 1);
          if (special) begin
            state    <= FIN;
            done_q   <= 1'b1;
            result_q <= fin_ld;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          hi_q    <= hi_s;
          lo_q    <= lo_s;
          count_q <= count_q - 1'b1;
          if (count_q == '0) begin
            state    <= FIN;
            done_q   <= 1'b1;
            result_q <= fin_step;
          end
        end
        FIN: if (!bus.hold_E) begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall is combinational so the pipe freezes in the very cycle the op is accepted.
  assign bus.stall_md  = !rst && !bus.flush_E &&
                         (((state == IDLE) && bus.start_E) || (state == CALC));
  assign bus.done_md   = done_q;
  assign bus.result_md = result_q;

endmodule
